edc_secded_pipe: RTL and testbench
==================================

// Module: edc_secded_pipe
// PURPOSE
//  Parametrised, pipelined SEC-DED (extended Hamming) encoder/checker/corrector for ECC-protected memory.
//  Write: generates check bits. Read: computes syndrome, corrects single-bit errors, flags double-bit errors.
//  Sits between the cache/bus side and the ECC RAM; valid/ready on both sides; saturating error counters.
// PARAMETERS
//  DATA_WIDTH  32  data word width, 4..64.
//  ECC_WIDTH   7   check bits incl. overall parity; must satisfy 2**(ECC_WIDTH-1) >= DATA_WIDTH+ECC_WIDTH.
//  CNT_WIDTH   16  width of each error counter.
// PORTS
//  i_clk          in   1           clock, all state on rising edge.
//  i_reset_n      in   1           asynchronous, active-low reset.
//  i_valid        in   1           input beat valid.
//  o_ready        out  1           block can accept a beat this cycle.
//  i_write        in   1           1 = encode (write path), 0 = check/correct (read path).
//  i_data         in   DATA_WIDTH  data word (raw on write, as read from RAM on read).
//  i_ecc          in   ECC_WIDTH   stored check bits (read only; ignored on write).
//  o_valid        out  1           output beat valid.
//  i_ready        in   1           downstream accepts output beat.
//  o_data         out  DATA_WIDTH  write: i_data unchanged; read: corrected data.
//  o_ecc          out  ECC_WIDTH   write: generated check bits; read: syndrome {overall, s[ECC_WIDTH-2:0]}.
//  o_err_corr     out  1           read beat had a single-bit error (corrected).
//  o_err_uncorr   out  1           read beat had an uncorrectable error.
//  i_cnt_clr      in   1           synchronous clear of both counters.
//  o_cnt_corr     out  CNT_WIDTH   accepted correctable-error beats, saturating.
//  o_cnt_uncorr   out  CNT_WIDTH   accepted uncorrectable-error beats, saturating.
// BEHAVIOUR
//  Code: positions 1..N, N=DATA_WIDTH+ECC_WIDTH-1; check bit k at position 2**k (k=0..ECC_WIDTH-2);
//   data bits fill non-power-of-two positions ascending (data[0]@3, data[1]@5, data[2]@6, data[3]@7, data[4]@9..).
//  p[k] = XOR of data bits whose position has bit k set. ecc[ECC_WIDTH-1] = XOR of all data bits and all p[k].
//  Read: s[k] = p[k] ^ i_ecc[k]; ov = ^i_data ^ ^i_ecc. Decode:
//   s==0,ov==0: clean. ov==1,s==0: overall bit bad -> corr. ov==1,s power of two: check bit bad -> corr, data unchanged.
//   ov==1,s maps to data position: flip that bit -> corr. ov==1,s>N: uncorr. ov==0,s!=0: uncorr (double).
//   On uncorr, o_data = i_data unmodified. Write beats: o_err_* = 0.
//  Pipeline: 2 register stages; S1 registers data, p/s, ov, mode; S2 registers corrected data + flags.
//   Latency 2 cycles from accepted input (i_valid&o_ready) to o_valid with no backpressure.
//  Handshake: stage advances when next stage empty or being emptied; o_ready = !S1 full | S1 advancing.
//   Full throughput 1 beat/cycle; with i_ready=0, both stages hold, o_ready drops after 2 beats buffered.
//   Outputs stable while o_valid&!i_ready. i_data/i_ecc/i_write sampled only on acceptance.
//  Counters: increment on accepted output beat (o_valid&i_ready) with matching flag; hold at all-ones.
//   i_cnt_clr wins over a same-cycle increment (result 0).
//  Reset (any time, incl. mid-stream): both stages invalid, o_valid=0, o_data/o_ecc=0, o_err_*=0,
//   counters=0; in-flight beats discarded. o_ready=1 out of reset.
// TESTING (DATA_WIDTH=32, ECC_WIDTH=7)
//  Write data 0x00000001 -> o_ecc=7'h43, o_data=0x1, o_valid exactly 2 cycles after accept.
//  Read data 0x00000001, ecc 7'h43 -> o_data=0x1, syndrome 0, no flags, counters unchanged.
//  Read data 0x00000000, ecc 7'h43 -> o_data=0x1, o_ecc=7'h43 (s=3, ov=1), o_err_corr=1, o_cnt_corr=1.
//  Read data 0x00000003, ecc 7'h00 -> s=6, ov=0, o_err_uncorr=1, o_data=0x3, o_cnt_uncorr=1.
//  Stream 4 beats with i_ready low cycles 2-4 -> o_ready low after 2 beats, in-order, none lost or duplicated.
//  Force counter to max then another error -> stays max; i_cnt_clr with error same cycle -> 0; reset mid-stream -> o_valid=0.

Source files
------------

// File: rtl/edc_secded_pipe.sv
// Two-stage SEC-DED (extended Hamming) encoder / checker / corrector.
// Valid/ready on both sides; saturating correctable/uncorrectable counters.
module edc_secded_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int ECC_WIDTH  = 7,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_write,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [ECC_WIDTH-1:0]  i_ecc,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [ECC_WIDTH-1:0]  o_ecc,
  output logic                  o_err_corr,
  output logic                  o_err_uncorr,
  input  logic                  i_cnt_clr,
  output logic [CNT_WIDTH-1:0]  o_cnt_corr,
  output logic [CNT_WIDTH-1:0]  o_cnt_uncorr
);

  localparam int PW = ECC_WIDTH - 1;
  localparam int N  = DATA_WIDTH + ECC_WIDTH - 1;

  // Code position of data bit j: j-th non-power-of-two position in 1..N.
  function automatic int dpos(input int j);
    int idx;
    int r;
    idx = 0;
    r   = 0;
    for (int q = 1; q <= N; q++) begin
      if ((q & (q - 1)) != 0) begin
        if (idx == j) r = q;
        idx++;
      end
    end
    return r;
  endfunction

  logic                  s1_v_q, s1_v_d;
  logic                  s1_wr_q;
  logic [DATA_WIDTH-1:0] s1_data_q;
  logic [PW-1:0]         s1_syn_q;
  logic                  s1_ov_q;

  logic                  s2_v_q, s2_v_d;
  logic [DATA_WIDTH-1:0] s2_data_q;
  logic [ECC_WIDTH-1:0]  s2_ecc_q;
  logic                  s2_corr_q, s2_unc_q;

  logic [CNT_WIDTH-1:0]  cnt_corr_q, cnt_corr_d;
  logic [CNT_WIDTH-1:0]  cnt_unc_q, cnt_unc_d;

  logic [PW-1:0]         enc_p;
  logic [DATA_WIDTH-1:0] flip;
  logic                  s2_free, s1_adv, accept;

  for (genvar k = 0; k < PW; k++) begin : g_p
    logic [DATA_WIDTH-1:0] m;
    for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_m
      localparam int P = dpos(j);
      assign m[j] = P[k];
    end
    assign enc_p[k] = ^(i_data & m);
  end

  for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_f
    localparam int P = dpos(j);
    assign flip[j] = (s1_syn_q == PW'(P));
  end

  assign s2_free = !s2_v_q || i_ready;
  assign s1_adv  = s1_v_q && s2_free;
  assign o_ready = !s1_v_q || s1_adv;
  assign accept  = i_valid && o_ready;

  logic                  syn_big;
  logic                  rd_corr, rd_unc;
  logic [DATA_WIDTH-1:0] fix_data;

  always_comb begin
    syn_big  = (32'(s1_syn_q) > 32'(N));
    rd_corr  = s1_ov_q && !syn_big;
    rd_unc   = (s1_ov_q && syn_big) || (!s1_ov_q && (|s1_syn_q));
    fix_data = rd_corr ? (s1_data_q ^ flip) : s1_data_q;
  end

  always_comb begin
    s1_v_d = s1_v_q;
    if (accept)      s1_v_d = 1'b1;
    else if (s1_adv) s1_v_d = 1'b0;
    s2_v_d = s2_v_q;
    if (s1_adv)       s2_v_d = 1'b1;
    else if (i_ready) s2_v_d = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_v_q    <= 1'b0;
      s1_wr_q   <= 1'b0;
      s1_data_q <= '0;
      s1_syn_q  <= '0;
      s1_ov_q   <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      if (accept) begin
        s1_wr_q   <= i_write;
        s1_data_q <= i_data;
        s1_syn_q  <= i_write ? enc_p : (enc_p ^ i_ecc[PW-1:0]);
        s1_ov_q   <= i_write ? (^i_data ^ ^enc_p) : (^i_data ^ ^i_ecc);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
      s2_ecc_q  <= '0;
      s2_corr_q <= 1'b0;
      s2_unc_q  <= 1'b0;
    end else begin
      s2_v_q <= s2_v_d;
      if (s1_adv) begin
        s2_data_q <= s1_wr_q ? s1_data_q : fix_data;
        s2_ecc_q  <= {s1_ov_q, s1_syn_q};
        s2_corr_q <= !s1_wr_q && rd_corr;
        s2_unc_q  <= !s1_wr_q && rd_unc;
      end
    end
  end

  // Clear has priority over a same-cycle increment.
  always_comb begin
    cnt_corr_d = cnt_corr_q;
    cnt_unc_d  = cnt_unc_q;
    if (i_cnt_clr) begin
      cnt_corr_d = '0;
      cnt_unc_d  = '0;
    end else if (s2_v_q && i_ready) begin
      if (s2_corr_q && !(&cnt_corr_q)) cnt_corr_d = cnt_corr_q + 1'b1;
      if (s2_unc_q && !(&cnt_unc_q))   cnt_unc_d  = cnt_unc_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_corr_q <= '0;
      cnt_unc_q  <= '0;
    end else begin
      cnt_corr_q <= cnt_corr_d;
      cnt_unc_q  <= cnt_unc_d;
    end
  end

  assign o_valid      = s2_v_q;
  assign o_data       = s2_data_q;
  assign o_ecc        = s2_ecc_q;
  assign o_err_corr   = s2_corr_q;
  assign o_err_uncorr = s2_unc_q;
  assign o_cnt_corr   = cnt_corr_q;
  assign o_cnt_uncorr = cnt_unc_q;

endmodule

// File: tb/tb_edc_secded_pipe.sv
// Directed bench for edc_secded_pipe: encode, correct, detect,
// backpressure stream, counter saturation/clear, mid-stream reset.
module tb_edc_secded_pipe;

  localparam int DW = 32;
  localparam int EW = 7;
  localparam int CW = 3;
  localparam int CMAX = 7;

  logic          clk;
  logic          rst_n;
  logic          i_valid;
  logic          o_ready;
  logic          i_write;
  logic [DW-1:0] i_data;
  logic [EW-1:0] i_ecc;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic [EW-1:0] o_ecc;
  logic          o_err_corr;
  logic          o_err_uncorr;
  logic          i_cnt_clr;
  logic [CW-1:0] o_cnt_corr;
  logic [CW-1:0] o_cnt_uncorr;

  edc_secded_pipe #(
    .DATA_WIDTH(DW),
    .ECC_WIDTH (EW),
    .CNT_WIDTH (CW)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_write     (i_write),
    .i_data      (i_data),
    .i_ecc       (i_ecc),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_ecc       (o_ecc),
    .o_err_corr  (o_err_corr),
    .o_err_uncorr(o_err_uncorr),
    .i_cnt_clr   (i_cnt_clr),
    .o_cnt_corr  (o_cnt_corr),
    .o_cnt_uncorr(o_cnt_uncorr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int exp_c  = 0;
  int exp_u  = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One beat with i_ready high; starts and ends 1 time unit after a posedge.
  task automatic beat(input string tag, input logic wr,
                      input logic [DW-1:0] d, input logic [EW-1:0] e,
                      input logic [DW-1:0] xd, input logic [EW-1:0] xe,
                      input logic xc, input logic xu, input logic clr);
    int lat;
    i_write = wr;
    i_data  = d;
    i_ecc   = e;
    i_valid = 1'b1;
    i_ready = 1'b1;
    #1;
    chk({tag, " o_ready"}, 64'(o_ready), 64'd1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_data  = $urandom;
    i_ecc   = EW'($urandom);
    i_write = 1'($urandom);
    lat = 1;
    while (!o_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'd2);
    chk({tag, " data"}, 64'(o_data), 64'(xd));
    chk({tag, " ecc"}, 64'(o_ecc), 64'(xe));
    chk({tag, " corr"}, 64'(o_err_corr), 64'(xc));
    chk({tag, " uncorr"}, 64'(o_err_uncorr), 64'(xu));
    if (clr) begin
      exp_c = 0;
      exp_u = 0;
    end else begin
      if (xc && exp_c < CMAX) exp_c++;
      if (xu && exp_u < CMAX) exp_u++;
    end
    i_cnt_clr = clr;
    @(posedge clk); #1;
    i_cnt_clr = 1'b0;
    chk({tag, " cnt_corr"}, 64'(o_cnt_corr), 64'(exp_c));
    chk({tag, " cnt_uncorr"}, 64'(o_cnt_uncorr), 64'(exp_u));
  endtask

  logic [DW-1:0] sd [4];
  logic [EW-1:0] se [4];

  initial begin
    int sent, recv, sent_at_low, c;
    logic saw_low;
    rst_n     = 1'b0;
    i_valid   = 1'b0;
    i_write   = 1'b0;
    i_data    = '0;
    i_ecc     = '0;
    i_ready   = 1'b1;
    i_cnt_clr = 1'b0;
    #12;
    chk("rst o_valid", 64'(o_valid), 64'd0);
    chk("rst o_ready", 64'(o_ready), 64'd1);
    chk("rst o_data", 64'(o_data), 64'd0);
    chk("rst o_ecc", 64'(o_ecc), 64'd0);
    chk("rst cnt_corr", 64'(o_cnt_corr), 64'd0);
    chk("rst cnt_uncorr", 64'(o_cnt_uncorr), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    beat("wr1", 1, 32'h1, 7'h00, 32'h1, 7'h43, 0, 0, 0);
    beat("wr_msb", 1, 32'h8000_0000, 7'h00, 32'h8000_0000, 7'h26, 0, 0, 0);
    beat("rd_clean", 0, 32'h1, 7'h43, 32'h1, 7'h00, 0, 0, 0);
    beat("rd_d0", 0, 32'h0, 7'h43, 32'h1, 7'h43, 1, 0, 0);
    beat("rd_dbl", 0, 32'h3, 7'h00, 32'h3, 7'h06, 0, 1, 0);
    beat("rd_ovbit", 0, 32'h1, 7'h03, 32'h1, 7'h40, 1, 0, 0);
    beat("rd_p0", 0, 32'h1, 7'h42, 32'h1, 7'h41, 1, 0, 0);
    beat("rd_d31", 0, 32'h0, 7'h26, 32'h8000_0000, 7'h66, 1, 0, 0);
    beat("rd_big", 0, 32'h0, 7'h7F, 32'h0, 7'h7F, 0, 1, 0);

    // Backpressure stream: i_ready low in cycles 2..4.
    sd[0] = 32'h1;         se[0] = 7'h43;
    sd[1] = 32'h8000_0000; se[1] = 7'h26;
    sd[2] = 32'h0;         se[2] = 7'h00;
    sd[3] = 32'h8000_0001; se[3] = 7'h65;
    sent = 0;
    recv = 0;
    saw_low = 1'b0;
    sent_at_low = -1;
    c = 0;
    i_write = 1'b1;
    while (recv < 4 && c < 40) begin
      i_ready = !(c >= 2 && c <= 4);
      i_valid = (sent < 4);
      i_data  = sent < 4 ? sd[sent] : 32'h0;
      #1;
      if (!o_ready && !saw_low) begin
        saw_low = 1'b1;
        sent_at_low = sent;
      end
      if (!i_ready) begin
        chk("stall o_valid", 64'(o_valid), 64'd1);
        chk("stall o_data", 64'(o_data), 64'(sd[recv]));
      end
      if (o_valid && i_ready) begin
        chk("stream data", 64'(o_data), 64'(sd[recv]));
        chk("stream ecc", 64'(o_ecc), 64'(se[recv]));
        recv++;
      end
      if (i_valid && o_ready) sent++;
      @(posedge clk); #1;
      c++;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    chk("stream recv", 64'(recv), 64'd4);
    chk("stream sent_at_low", 64'(sent_at_low), 64'd2);
    @(posedge clk); #1;
    chk("stream drained", 64'(o_valid), 64'd0);

    for (int i = 0; i < 8; i++)
      beat("sat", 0, 32'h3, 7'h00, 32'h3, 7'h06, 0, 1, 0);
    chk("sat max", 64'(o_cnt_uncorr), 64'(CMAX));
    beat("clr_err", 0, 32'h0, 7'h43, 32'h1, 7'h43, 1, 0, 1);

    // Reset with both stages full.
    beat("pre_rst", 0, 32'h0, 7'h43, 32'h1, 7'h43, 1, 0, 0);
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_write = 1'b1;
    i_data  = 32'h1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("mid o_valid", 64'(o_valid), 64'd1);
    i_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst o_valid", 64'(o_valid), 64'd0);
    chk("mid rst o_ready", 64'(o_ready), 64'd1);
    chk("mid rst o_data", 64'(o_data), 64'd0);
    chk("mid rst cnt_corr", 64'(o_cnt_corr), 64'd0);
    exp_c = 0;
    exp_u = 0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post rst o_valid", 64'(o_valid), 64'd0);
    beat("post_rst", 1, 32'h1, 7'h00, 32'h1, 7'h43, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
